aes_core_arbiter: RTL and testbench

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

---
 rtl/aes_arb_pkg.sv | 15 +
 rtl/aes_core_arbiter_if.sv | 35 +++
 rtl/aes_arb_rr_pick.sv | 19 +
 rtl/aes_core_arbiter.sv | 136 +++++++++++++
 tb/tb_aes_core_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and sizes for the two-requester AES core arbiter.
// Imported by the interface, the round-robin picker and the top.
package aes_arb_pkg;
    localparam int NUM_REQ     = 2;
    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0]     blk_t;
    typedef logic [$clog2(NUM_REQ)-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;
endpackage

// File: rtl/aes_core_arbiter_if.sv
// Requester and AES-core signal bundle of the arbiter.
// Names are seen from the arbiter side; slave is the arbiter.
interface aes_core_arbiter_if;
    import aes_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_i;
    blk_t [NUM_REQ-1:0]        key_i;
    blk_t [NUM_REQ-1:0]        data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    blk_t                      rsp_data_o;
    logic                      core_valid_o;
    blk_t                      core_key_o;
    blk_t                      core_data_o;
    logic                      core_valid_i;
    blk_t                      core_data_i;
    logic                      busy_o;
    logic                      timeout_o;

    modport slave (
        input  req_i, key_i, data_i,
        input  core_valid_i, core_data_i,
        output gnt_o, rsp_valid_o, rsp_data_o,
        output core_valid_o, core_key_o, core_data_o,
        output busy_o, timeout_o
    );

    modport master (
        output req_i, key_i, data_i,
        output core_valid_i, core_data_i,
        input  gnt_o, rsp_valid_o, rsp_data_o,
        input  core_valid_o, core_key_o, core_data_o,
        input  busy_o, timeout_o
    );
endinterface

// File: rtl/aes_arb_rr_pick.sv
// Round-robin pick between two requesters.
// A lone request wins; on a tie the one not served last wins.
module aes_arb_rr_pick
    import aes_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  idx_t               last_i,
    output logic [NUM_REQ-1:0] pick_o
);
    always_comb begin
        pick_o = '0;
        unique case (1'b1)
            (req_i == 2'b01): pick_o = 2'b01;
            (req_i == 2'b10): pick_o = 2'b10;
            (req_i == 2'b11): pick_o = last_i[0] ? 2'b01 : 2'b10;
            default:          pick_o = '0;
        endcase
    end
endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core between two requesters (IDLE/BUSY/RESP).
// Define AES_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_core_arbiter_if.slave  bus
);
    arb_state_e         state_q, state_d;
    idx_t               owner_q, owner_d;
    idx_t               last_q, last_d;
    blk_t               key_q, key_d;
    blk_t               data_q, data_d;
    blk_t               rsp_q, rsp_d;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_vld;
    logic               core_vld;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    aes_arb_rr_pick u_pick (
        .req_i  (bus.req_i),
        .last_i (last_q),
        .pick_o (pick)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        key_d    = key_q;
        data_d   = data_q;
        rsp_d    = rsp_q;
        gnt      = '0;
        rsp_vld  = '0;
        core_vld = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    gnt     = pick;
                    owner_d = idx_t'(pick[1]);
                    key_d   = bus.key_i[pick[1]];
                    data_d  = bus.data_i[pick[1]];
                    state_d = BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                core_vld = 1'b1;
                // A result on the final count beats the timeout.
                if (bus.core_valid_i) begin
                    rsp_d   = bus.core_data_i;
                    state_d = RESP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    rsp_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rsp_vld = NUM_REQ'(1) << owner_q;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= idx_t'(1);
            key_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            key_q   <= key_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.timeout_o = tmo_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    // Grant is combinational from req_i, so mask it while reset is held.
    assign bus.gnt_o        = gnt & {NUM_REQ{rst_n}};
    assign bus.rsp_valid_o  = rsp_vld;
    assign bus.rsp_data_o   = rsp_q;
    assign bus.core_valid_o = core_vld;
    assign bus.core_key_o   = core_vld ? key_q : '0;
    assign bus.core_data_o  = core_vld ? data_q : '0;
    assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed plus randomized checks of aes_core_arbiter against a
// transaction-level model; define AES_ARB_TIMEOUT_EN to cover timeouts.
module tb_aes_core_arbiter;
    import aes_arb_pkg::*;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    int   m_last;
    blk_t m_rsp;

    aes_core_arbiter_if bus ();

    aes_core_arbiter #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic blk_t rnd_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input blk_t obs, input blk_t exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction starting in IDLE just after a posedge.
    task automatic txn(
        input  logic [1:0] req,
        input  bit         hold,
        input  int         lat,
        input  bit         respond,
        input  bit         scramble,
        input  blk_t       k0, k1, d0, d1, cd,
        output logic [1:0] won
    );
        int   o;
        blk_t ek, ed;
        if (req == 2'b11) o = (m_last == 0) ? 1 : 0;
        else              o = req[1] ? 1 : 0;
        won = 2'b01 << o;
        ek  = (o == 0) ? k0 : k1;
        ed  = (o == 0) ? d0 : d1;
        bus.key_i[0]  = k0;
        bus.key_i[1]  = k1;
        bus.data_i[0] = d0;
        bus.data_i[1] = d1;
        bus.req_i     = req;
        @(negedge clk);
        chk("gnt", blk_t'(bus.gnt_o), blk_t'(won));
        chk("idle_busy", blk_t'(bus.busy_o), '0);
        chk("idle_cvalid", blk_t'(bus.core_valid_o), '0);
        chk("idle_ckey", bus.core_key_o, '0);
        chk("idle_rsp_hold", bus.rsp_data_o, m_rsp);
        @(posedge clk); #1;
        if (!hold) bus.req_i = req & ~won;
        if (scramble) begin
            bus.key_i  = '1;
            bus.data_i = '1;
        end
        for (int c = 1; c <= lat; c++) begin
            if (respond && c == lat) begin
                bus.core_valid_i = 1'b1;
                bus.core_data_i  = cd;
            end
            @(negedge clk);
            chk("busy", blk_t'(bus.busy_o), blk_t'(1));
            chk("cvalid", blk_t'(bus.core_valid_o), blk_t'(1));
            chk("ckey", bus.core_key_o, ek);
            chk("cdata", bus.core_data_o, ed);
            chk("busy_rsp_valid", blk_t'(bus.rsp_valid_o), '0);
            chk("busy_gnt", blk_t'(bus.gnt_o), '0);
            chk("busy_rsp_hold", bus.rsp_data_o, m_rsp);
            @(posedge clk); #1;
            bus.core_valid_i = 1'b0;
            bus.core_data_i  = rnd_blk();
        end
        m_rsp = respond ? cd : '0;
        bus.core_valid_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rsp_valid", blk_t'(bus.rsp_valid_o), blk_t'(won));
        chk("rsp_data", bus.rsp_data_o, m_rsp);
        chk("timeout", blk_t'(bus.timeout_o), blk_t'(!respond));
        chk("resp_cvalid", blk_t'(bus.core_valid_o), '0);
        chk("resp_ckey", bus.core_key_o, '0);
        m_last = o;
        @(posedge clk); #1;
        bus.core_valid_i = 1'b0;
        if (!hold) bus.req_i = 2'b00;
    endtask

    initial begin
        logic [1:0] w;
        logic [1:0] tie_exp [4];
        bit         resp;
        int         lat;
        vectors = 0;
        errors  = 0;
        m_last  = 1;
        m_rsp   = '0;
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst_n            = 1'b0;
        bus.req_i        = 2'b11;
        bus.key_i        = '1;
        bus.data_i       = '1;
        bus.core_valid_i = 1'b1;
        bus.core_data_i  = '1;

        @(negedge clk);
        chk("rst_gnt", blk_t'(bus.gnt_o), '0);
        chk("rst_busy", blk_t'(bus.busy_o), '0);
        chk("rst_cvalid", blk_t'(bus.core_valid_o), '0);
        chk("rst_ckey", bus.core_key_o, '0);
        chk("rst_cdata", bus.core_data_o, '0);
        chk("rst_rsp_valid", blk_t'(bus.rsp_valid_o), '0);
        chk("rst_rsp_data", bus.rsp_data_o, '0);
        chk("rst_timeout", blk_t'(bus.timeout_o), '0);
        @(posedge clk); #1;
        bus.req_i        = 2'b00;
        bus.core_valid_i = 1'b0;
        rst_n            = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 1'b1, 3 + i, 1'b1, 1'b0, rnd_blk(), rnd_blk(),
                rnd_blk(), rnd_blk(), rnd_blk(), w);
            chk("tie_order", blk_t'(w), blk_t'(tie_exp[i]));
        end
        bus.req_i = 2'b00;
        @(posedge clk); #1;

        txn(2'b01, 1'b0, 10, 1'b1, 1'b0,
            128'h000102030405060708090a0b0c0d0e0f, rnd_blk(),
            128'h00112233445566778899aabbccddeeff, rnd_blk(),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, w);
        chk("fips_gnt", blk_t'(w), blk_t'(2'b01));
        chk("fips_rsp", bus.rsp_data_o,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        txn(2'b10, 1'b0, 6, 1'b1, 1'b1, rnd_blk(), rnd_blk(),
            rnd_blk(), rnd_blk(), rnd_blk(), w);

        bus.core_valid_i = 1'b1;
        bus.core_data_i  = {4{32'haaaaaaaa}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_busy", blk_t'(bus.busy_o), '0);
            chk("stray_rsp_valid", blk_t'(bus.rsp_valid_o), '0);
            chk("stray_rsp_data", bus.rsp_data_o, m_rsp);
            @(posedge clk); #1;
        end
        bus.core_valid_i = 1'b0;

        bus.req_i = 2'b01;
        @(negedge clk);
        chk("rstop_gnt", blk_t'(bus.gnt_o), blk_t'(2'b01));
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstop_cvalid", blk_t'(bus.core_valid_o), blk_t'(1));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        bus.core_valid_i = 1'b1;
        #1;
        chk("rstop_cvalid_drop", blk_t'(bus.core_valid_o), '0);
        chk("rstop_busy_drop", blk_t'(bus.busy_o), '0);
        chk("rstop_rsp_data", bus.rsp_data_o, '0);
        @(posedge clk); #1;
        bus.core_valid_i = 1'b0;
        rst_n = 1'b1;
        m_last = 1;
        m_rsp  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstop_no_rsp", blk_t'(bus.rsp_valid_o), '0);
            @(posedge clk); #1;
        end
        txn(2'b11, 1'b0, 2, 1'b1, 1'b0, rnd_blk(), rnd_blk(),
            rnd_blk(), rnd_blk(), rnd_blk(), w);
        chk("rstop_ptr", blk_t'(w), blk_t'(2'b01));

`ifdef AES_ARB_TIMEOUT_EN
        txn(2'b01, 1'b0, TMO, 1'b0, 1'b0, rnd_blk(), rnd_blk(),
            rnd_blk(), rnd_blk(), rnd_blk(), w);
        txn(2'b10, 1'b0, TMO, 1'b1, 1'b0, rnd_blk(), rnd_blk(),
            rnd_blk(), rnd_blk(), rnd_blk(), w);
`else
        txn(2'b10, 1'b0, 100, 1'b1, 1'b0, rnd_blk(), rnd_blk(),
            rnd_blk(), rnd_blk(), rnd_blk(), w);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef AES_ARB_TIMEOUT_EN
            resp = ($urandom_range(0, 3) != 0);
            lat  = resp ? int'($urandom_range(1, TMO)) : TMO;
`else
            resp = 1'b1;
            lat  = int'($urandom_range(1, 12));
`endif
            txn(2'($urandom_range(1, 3)), 1'b0, lat, resp,
                1'($urandom_range(0, 1)), rnd_blk(), rnd_blk(),
                rnd_blk(), rnd_blk(), rnd_blk(), w);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
